// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the FFT complex-multiplier slice.
//   DW_DEF / CW_DEF : default data / twiddle widths (Q1.(W-1) two's complement)
//   LAT             : fixed input-accept to output-valid latency of fft_cmul_pipe
//   q_max / q_min   : largest / smallest value of a W-bit Q1.(W-1) word
//   sat_bounds      : both saturation limits of a W-bit word bundled together
package fft_pkg;

  localparam int DW_DEF = 16;
  localparam int CW_DEF = 8;
  localparam int LAT    = 3;

  typedef struct packed {
    logic signed [63:0] max;
    logic signed [63:0] min;
  } sat_bounds_t;

  function automatic logic signed [63:0] q_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] q_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic sat_bounds_t sat_bounds(input int w);
    sat_bounds_t b;
    b.max = q_max(w);
    b.min = q_min(w);
    return b;
  endfunction

endpackage

// File: rtl/fft_cmul_pipe_if.sv
// fft_cmul_pipe_if: valid/ready bus of the complex multiplier.
//   Input side : in_valid, in_ready, in_re, in_im, tw_re, tw_im, conj
//   Output side: out_valid, out_ready, out_re, out_im, out_sat
//   master = traffic source/sink around the block, slave = fft_cmul_pipe itself.
interface fft_cmul_pipe_if
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic signed [CW-1:0] tw_re;
  logic signed [CW-1:0] tw_im;
  logic                 conj;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic                 out_sat;

  modport master (
    output in_valid, in_re, in_im, tw_re, tw_im, conj, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_sat
  );

  modport slave (
    input  in_valid, in_re, in_im, tw_re, tw_im, conj, out_ready,
    output in_ready, out_valid, out_re, out_im, out_sat
  );
endinterface

// File: rtl/fft_cmul_scale.sv
// fft_cmul_scale: rescales one full-width complex-product component to DW bits.
//   x    : combined sum, SW = DW+CW+1 bits, scale 2^(CW-1) too large
//   y    : x >>> (CW-1), saturated to the DW-bit Q1.(DW-1) range
//   clip : 1 when y was clipped
// Macro FFT_CMUL_ROUND_EN: when defined, round half up before the shift;
// when undefined, plain floor truncation with no rounding adder.
module fft_cmul_scale
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int SW = DW + CW + 1
) (
  input  logic signed [SW-1:0] x,
  output logic signed [DW-1:0] y,
  output logic                 clip
);

  // One spare bit so the rounding increment can never wrap.
  localparam int XW = SW + 1;
  localparam sat_bounds_t B = sat_bounds(DW);
  localparam logic signed [XW-1:0] MAX_C = XW'(B.max);
  localparam logic signed [XW-1:0] MIN_C = XW'(B.min);
`ifdef FFT_CMUL_ROUND_EN
  localparam logic signed [XW-1:0] HALF_C = XW'(64'sd1 <<< (CW - 2));
`endif

  logic signed [XW-1:0] ext_s;
  logic signed [XW-1:0] shr_s;

  // Optional round, arithmetic shift, then clamp to the output range.
  always_comb begin
`ifdef FFT_CMUL_ROUND_EN
    ext_s = XW'(x) + HALF_C;
`else
    ext_s = XW'(x);
`endif
    shr_s = ext_s >>> (CW - 1);
    if (shr_s > MAX_C) begin
      y    = MAX_C[DW-1:0];
      clip = 1'b1;
    end else if (shr_s < MIN_C) begin
      y    = MIN_C[DW-1:0];
      clip = 1'b1;
    end else begin
      y    = shr_s[DW-1:0];
      clip = 1'b0;
    end
  end

endmodule

// File: rtl/fft_cmul_pipe.sv
// fft_cmul_pipe: 3-stage pipelined complex multiplier, out = in * tw (or in * conj(tw)).
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, flushes the pipe
//   bus  : fft_cmul_pipe_if.slave (input sample + twiddle + conj, output word + out_sat)
// Stages: S1 registers inputs, S2 registers the four partial products,
// S3 combines/scales/saturates into the output registers. A single global
// advance (out_ready | ~out_valid) moves every stage; bubbles are kept.
// Macro FFT_CMUL_ROUND_EN selects round-half-up scaling (see fft_cmul_scale).
module fft_cmul_pipe
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  fft_cmul_pipe_if.slave  bus
);

  localparam int PW = DW + CW;      // one product
  localparam int SW = DW + CW + 1;  // sum/difference of two products

  logic                 adv_s;
  logic                 v1_r, conj1_r;
  logic signed [DW-1:0] re1_r, im1_r;
  logic signed [CW-1:0] wr1_r, wi1_r;
  logic signed [PW-1:0] pa_s, pb_s, pc_s, pd_s;
  logic                 v2_r, conj2_r;
  logic signed [PW-1:0] pa_r, pb_r, pc_r, pd_r;
  logic signed [SW-1:0] sum_re_s, sum_im_s;
  logic signed [DW-1:0] y_re_s, y_im_s;
  logic                 clip_re_s, clip_im_s;
  logic                 v3_r, sat3_r;
  logic signed [DW-1:0] out_re_r, out_im_r;

  assign adv_s        = bus.out_ready | ~v3_r;
  assign bus.in_ready = adv_s & ~rst;

  // S1: capture sample, twiddle and conj mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r    <= 1'b0;
      conj1_r <= 1'b0;
      re1_r   <= '0;
      im1_r   <= '0;
      wr1_r   <= '0;
      wi1_r   <= '0;
    end else if (adv_s) begin
      v1_r    <= bus.in_valid;
      conj1_r <= bus.conj;
      re1_r   <= bus.in_re;
      im1_r   <= bus.in_im;
      wr1_r   <= bus.tw_re;
      wi1_r   <= bus.tw_im;
    end
  end

  // Four signed partial products at full precision.
  always_comb begin
    pa_s = PW'(re1_r) * PW'(wr1_r);
    pb_s = PW'(im1_r) * PW'(wi1_r);
    pc_s = PW'(re1_r) * PW'(wi1_r);
    pd_s = PW'(im1_r) * PW'(wr1_r);
  end

  // S2: register the partial products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r    <= 1'b0;
      conj2_r <= 1'b0;
      pa_r    <= '0;
      pb_r    <= '0;
      pc_r    <= '0;
      pd_r    <= '0;
    end else if (adv_s) begin
      v2_r    <= v1_r;
      conj2_r <= conj1_r;
      pa_r    <= pa_s;
      pb_r    <= pb_s;
      pc_r    <= pc_s;
      pd_r    <= pd_s;
    end
  end

  // Conjugation flips add/sub rather than negating tw_im, so tw_im = -2^(CW-1) stays exact.
  always_comb begin
    sum_re_s = '0;
    sum_im_s = '0;
    if (conj2_r) begin
      sum_re_s = SW'(pa_r) + SW'(pb_r);
      sum_im_s = SW'(pd_r) - SW'(pc_r);
    end else begin
      sum_re_s = SW'(pa_r) - SW'(pb_r);
      sum_im_s = SW'(pc_r) + SW'(pd_r);
    end
  end

  fft_cmul_scale #(.DW(DW), .CW(CW), .SW(SW)) u_scale_re (
    .x    (sum_re_s),
    .y    (y_re_s),
    .clip (clip_re_s)
  );

  fft_cmul_scale #(.DW(DW), .CW(CW), .SW(SW)) u_scale_im (
    .x    (sum_im_s),
    .y    (y_im_s),
    .clip (clip_im_s)
  );

  // S3: output registers; bubbles leave zeroed data and a clear sat flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_r     <= 1'b0;
      sat3_r   <= 1'b0;
      out_re_r <= '0;
      out_im_r <= '0;
    end else if (adv_s) begin
      v3_r     <= v2_r;
      sat3_r   <= v2_r & (clip_re_s | clip_im_s);
      out_re_r <= v2_r ? y_re_s : '0;
      out_im_r <= v2_r ? y_im_s : '0;
    end
  end

  assign bus.out_valid = v3_r;
  assign bus.out_sat   = sat3_r;
  assign bus.out_re    = out_re_r;
  assign bus.out_im    = out_im_r;

endmodule

// File: tb/tb_fft_cmul_pipe.sv
// tb_fft_cmul_pipe: scoreboard bench for fft_cmul_pipe (DW=16, CW=8).
// The driver pushes the reference result of every accepted sample into exp_q;
// an independent monitor pops and compares whenever an output word transfers.
module tb_fft_cmul_pipe;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int CW = 8;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic signed [7:0]  wr;
    logic signed [7:0]  wi;
    logic               cj;
  } stim_t;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               sat;
    int                 acc_cyc;
    bit                 chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t  exp_q[$];
  stim_t stim_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_cmul_pipe_if #(.DW(DW), .CW(CW)) bus ();

  fft_cmul_pipe #(.DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scale one exact component by 2^-(CW-1) and clamp to 16-bit Q1.15.
  function automatic longint scale_sat(input longint x, inout bit clip);
    longint y;
`ifdef FFT_CMUL_ROUND_EN
    x = x + (64'sd1 <<< (CW - 2));
`endif
    y = x >>> (CW - 1);
    if (y > 64'sd32767) begin
      y = 64'sd32767;
      clip = 1'b1;
    end else if (y < -64'sd32768) begin
      y = -64'sd32768;
      clip = 1'b1;
    end
    return y;
  endfunction

  // Reference: exact complex product with tw or conj(tw), then scaling.
  function automatic exp_t model(input stim_t s);
    longint a_re, a_im, w_re, w_im, r, i;
    bit clip;
    exp_t e;
    a_re = longint'(s.re);
    a_im = longint'(s.im);
    w_re = longint'(s.wr);
    w_im = s.cj ? -longint'(s.wi) : longint'(s.wi);
    r = a_re * w_re - a_im * w_im;
    i = a_re * w_im + a_im * w_re;
    clip = 1'b0;
    e.re = 16'(scale_sat(r, clip));
    e.im = 16'(scale_sat(i, clip));
    e.sat = clip;
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  task automatic add(input int re, input int im, input int wr, input int wi, input bit cj);
    stim_t s;
    s.re = 16'(re);
    s.im = 16'(im);
    s.wr = 8'(wr);
    s.wi = 8'(wi);
    s.cj = cj;
    stim_q.push_back(s);
  endtask

  task automatic add_rand(input int n);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s.re = 16'($urandom());
      s.im = 16'($urandom());
      s.wr = ($urandom_range(0, 7) == 0) ? 8'sh80 : 8'($urandom());
      s.wi = ($urandom_range(0, 7) == 0) ? 8'sh80 : 8'($urandom());
      s.cj = 1'($urandom_range(0, 1));
      stim_q.push_back(s);
    end
  endtask

  // Push stim_q through the DUT. mode 0: no stalls (latency checked),
  // mode 1: random valid and ready, mode 2: continuous valid, ready low in cycles 4..6.
  task automatic run_stream(input int mode);
    int   idx;
    int   c;
    bit   v;
    bit   hold;
    exp_t e;
    idx = 0;
    c = 0;
    v = 1'b0;
    while (idx < stim_q.size() && c < 4000) begin
      @(posedge clk);
      #1;
      if (!v) v = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_valid = v;
      bus.in_re = stim_q[idx].re;
      bus.in_im = stim_q[idx].im;
      bus.tw_re = stim_q[idx].wr;
      bus.tw_im = stim_q[idx].wi;
      bus.conj  = stim_q[idx].cj;
      hold = (mode == 2) && (c >= 4) && (c <= 6);
      if (mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
      else bus.out_ready = !hold;
      @(negedge clk);
      if (hold) chk("in_ready_during_hold", bus.in_ready, 0);
      if (v && bus.in_ready) begin
        e = model(stim_q[idx]);
        e.acc_cyc = cyc;
        e.chk_lat = (mode == 0);
        exp_q.push_back(e);
        idx++;
        v = 1'b0;
      end
      c++;
    end
    if (idx < stim_q.size()) chk("stream_accept_timeout", idx, stim_q.size());
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) chk("drain_outstanding", exp_q.size(), 0);
    stim_q.delete();
  endtask

  // Monitor: score every transferred word and check stability while stalled.
  initial begin
    exp_t e;
    logic signed [15:0] h_re, h_im;
    logic h_sat;
    bit held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held && bus.out_valid) begin
          chk("hold_out_re", bus.out_re, h_re);
          chk("hold_out_im", bus.out_im, h_im);
          chk("hold_out_sat", bus.out_sat, h_sat);
        end
        held = bus.out_valid && !bus.out_ready;
        h_re = bus.out_re;
        h_im = bus.out_im;
        h_sat = bus.out_sat;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output_count", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_re", bus.out_re, e.re);
            chk("out_im", bus.out_im, e.im);
            chk("out_sat", bus.out_sat, e.sat);
            if (e.chk_lat) chk("latency", cyc - e.acc_cyc, LAT);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    exp_t  e;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    bus.tw_re = '0;
    bus.tw_im = '0;
    bus.conj = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_re", bus.out_re, 0);
    chk("reset_out_sat", bus.out_sat, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed: basic, conjugate, saturation, rounding corners.
    add(16384, 0, 127, 0, 1'b0);
    add(0, 16384, 0, 127, 1'b0);
    add(0, 16384, 0, 127, 1'b1);
    add(-32768, 0, -128, 0, 1'b0);
    add(-32768, 0, 0, -128, 1'b1);
    add(0, -32768, 0, -128, 1'b1);
    add(1, 0, 64, 0, 1'b0);
    add(-1, 0, 64, 0, 1'b0);
    add(-32768, -32768, -128, -128, 1'b0);
    add(-32768, -32768, -128, -128, 1'b1);
    add(32767, 32767, 127, 127, 1'b0);
    run_stream(0);

    // Backpressure: 8 back-to-back samples with a 3-cycle output stall.
    add_rand(8);
    run_stream(2);

    // Random traffic with random valid and ready.
    add_rand(300);
    run_stream(1);

    // Reset with samples in flight.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_re = 16'sd16384;
      bus.in_im = 16'(k * 1000);
      bus.tw_re = 8'sd127;
      bus.tw_im = 8'sd0;
      bus.conj = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("pre_reset_in_ready", bus.in_ready, 1);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("pre_reset_out_valid", bus.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_out_valid", bus.out_valid, 0);
    chk("async_reset_out_re", bus.out_re, 0);
    chk("async_reset_out_im", bus.out_im, 0);
    chk("async_reset_out_sat", bus.out_sat, 0);
    chk("async_reset_in_ready", bus.in_ready, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    add(-16384, 8192, 100, -50, 1'b1);
    add(12345, -2345, -77, 33, 1'b0);
    run_stream(0);

    repeat (5) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
